// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : bus_cycle_ctrl
//  Description : Minimum-mode 8088 bus-cycle sequencer. Accepts a physical
//                address plus read/write request from the BIU and runs the
//                external T1..T4 bus cycle on a demultiplexed view of the AD
//                bus. It inserts TW states while READY is low and returns
//                read bytes to the BIU. A bounded wait counter aborts hung
//                cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_WAIT   maximum consecutive TW states before abort (1..255)
//  Ports
//    clk        system clock, all state on rising edge
//    reset      asynchronous, active-low reset
//    req        cycle request, sampled only in IDLE or T4
//    rd_wr      1 = read, 0 = write (captured with req)
//    io_m       1 = I/O, 0 = memory (captured with req)
//    Direction  20-bit physical address (captured with req)
//    wr_data    write byte (captured with req)
//    READY      external ready, sampled in T3/TW
//    A_hi       address bits 19:8, held T1..T4
//    AD_out     address 7:0 in T1, write data T2..T4
//    AD_oe      AD pin drive enable
//    AD_in      AD pin input
//    ALE        address latch enable, T1 only
//    RD_n/WR_n  active-low read / write strobes
//    IO_M       captured io_m for the running cycle
//    DT_R       transceiver direction, 1 = transmit (write)
//    DEN_n      active-low transceiver enable
//    rd_data    byte captured on read completion
//    busy       high while a cycle is in progress
//    done       one-cycle pulse in T4
//    err        one-cycle pulse in T4 of an aborted cycle
// ============================================================================
module bus_cycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rd_wr,
    input  logic        io_m,
    input  logic [19:0] Direction,
    input  logic [7:0]  wr_data,
    input  logic        READY,
    output logic [11:0] A_hi,
    output logic [7:0]  AD_out,
    output logic        AD_oe,
    input  logic [7:0]  AD_in,
    output logic        ALE,
    output logic        RD_n,
    output logic        WR_n,
    output logic        IO_M,
    output logic        DT_R,
    output logic        DEN_n,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_T1   = 3'd1;
    localparam logic [2:0] c_S_T2   = 3'd2;
    localparam logic [2:0] c_S_T3   = 3'd3;
    localparam logic [2:0] c_S_TW   = 3'd4;
    localparam logic [2:0] c_S_T4   = 3'd5;

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    logic [2:0]  state_q, state_d;
    logic        rdwr_q;
    logic        iom_q;
    logic [19:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        abort_q, abort_d;
    logic [7:0]  rd_data_q;

    logic        w_accept;
    logic        w_timeout;
    logic        w_sample_rd;

    // A new request is only taken when the bus is free (IDLE) or finishing (T4),
    // which gives back-to-back cycles with no idle gap.
    assign w_accept    = req && ((state_q == c_S_IDLE) || (state_q == c_S_T4));

    // Counter already shows the number of TW states spent, so reaching the
    // limit while still not ready ends the cycle.
    assign w_timeout   = (state_q == c_S_TW) && !READY && (wait_cnt_q == c_MAX_WAIT);

    // Read data is latched on the edge that leaves T3/TW with READY high.
    assign w_sample_rd = rdwr_q && READY &&
                         ((state_q == c_S_T3) || (state_q == c_S_TW));

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: if (req) state_d = c_S_T1;
            c_S_T1:   state_d = c_S_T2;
            c_S_T2:   state_d = c_S_T3;
            c_S_T3:   state_d = READY ? c_S_T4 : c_S_TW;
            c_S_TW:   if (READY || w_timeout) state_d = c_S_T4;
            c_S_T4:   state_d = req ? c_S_T1 : c_S_IDLE;
            default:  state_d = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Wait counter and abort flag
    // ------------------------------------------------------------------------
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q == c_S_T3) && !READY) begin
            wait_cnt_d = 8'd1;
        end else if ((state_q == c_S_TW) && !READY && !w_timeout) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // The abort flag only lives through the T4 of the aborted cycle.
    always_comb begin
        abort_d = abort_q;
        if (state_q == c_S_T4) begin
            abort_d = 1'b0;
        end else if (w_timeout) begin
            abort_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture, counters and read data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdwr_q     <= 1'b0;
            iom_q      <= 1'b0;
            addr_q     <= 20'd0;
            wdata_q    <= 8'd0;
            wait_cnt_q <= 8'd0;
            abort_q    <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            if (w_accept) begin
                rdwr_q  <= rd_wr;
                iom_q   <= io_m;
                addr_q  <= Direction;
                wdata_q <= wr_data;
            end
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
            if (w_sample_rd) begin
                rd_data_q <= AD_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        logic w_busy;
        logic w_t1;
        logic w_t4;
        logic w_strobe;

        w_busy   = (state_q != c_S_IDLE);
        w_t1     = (state_q == c_S_T1);
        w_t4     = (state_q == c_S_T4);
        // Strobe window: T2, T3 and every TW.
        w_strobe = (state_q == c_S_T2) || (state_q == c_S_T3) || (state_q == c_S_TW);

        A_hi    = w_busy ? addr_q[19:8] : 12'd0;
        ALE     = w_t1;
        IO_M    = w_busy ? iom_q : 1'b0;
        DT_R    = w_busy ? ~rdwr_q : 1'b0;
        busy    = w_busy;
        done    = w_t4;
        err     = w_t4 && abort_q;
        rd_data = rd_data_q;

        AD_out  = 8'd0;
        AD_oe   = 1'b0;
        if (w_t1) begin
            AD_out = addr_q[7:0];
            AD_oe  = 1'b1;
        end else if (w_busy && !rdwr_q) begin
            AD_out = wdata_q;
            AD_oe  = 1'b1;
        end

        RD_n  = ~(w_strobe && rdwr_q);
        WR_n  = ~(w_strobe && !rdwr_q);
        // A write keeps the transceiver enabled through T4 so data stays
        // valid while WR_n rises; a read releases it as soon as data is taken.
        DEN_n = ~(w_strobe || (w_t4 && !rdwr_q));
    end

endmodule
`default_nettype wire
